// File: rtl/elementwise_mac_pipe.sv
// Elementwise multiply-accumulate over LANES lanes with valid/ready handshakes.
// Beats are grouped by first/last flags, and one accumulated result is emitted per group.
// Pipeline: operand capture -> product register -> accumulator/output register.
// The whole pipeline advances together whenever the output slot is free or is being drained.
module elementwise_mac_pipe #(
    parameter int LANES  = 16,
    parameter int IN_W   = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 0,
    parameter int SAT    = 0,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [LANES*IN_W-1:0]  in_u,
    input  logic [LANES*IN_W-1:0]  in_v,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*ACC_W-1:0] out_m,
    output logic [CNT_W-1:0]       out_beats,
    output logic                   err_seq
);

    logic                  adv;

    logic                  s_valid;
    logic                  s_first;
    logic                  s_last;
    logic [LANES*IN_W-1:0] s_u;
    logic [LANES*IN_W-1:0] s_v;

    logic [2*IN_W-1:0]     prod_c [LANES];
    logic [2*IN_W-1:0]     p_prod [LANES];
    logic                  p_valid;
    logic                  p_first;
    logic                  p_last;

    logic [ACC_W-1:0]      acc     [LANES];
    logic [ACC_W-1:0]      acc_nxt [LANES];
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  grp_open;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Operand capture: registers the accepted beat so the multiply starts from stable flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_valid <= 1'b0;
            s_first <= 1'b0;
            s_last  <= 1'b0;
            s_u     <= '0;
            s_v     <= '0;
        end else if (adv) begin
            s_valid <= in_valid;
            if (in_valid) begin
                s_first <= in_first;
                s_last  <= in_last;
                s_u     <= in_u;
                s_v     <= in_v;
            end
        end
    end

    // Lane products, full 2*IN_W width so no product ever overflows.
    always_comb begin
        logic [IN_W-1:0] ua;
        logic [IN_W-1:0] va;
        for (int i = 0; i < LANES; i++) begin
            ua = s_u[i*IN_W +: IN_W];
            va = s_v[i*IN_W +: IN_W];
            if (SIGNED != 0) begin
                prod_c[i] = $signed({{IN_W{ua[IN_W-1]}}, ua}) * $signed({{IN_W{va[IN_W-1]}}, va});
            end else begin
                prod_c[i] = {{IN_W{1'b0}}, ua} * {{IN_W{1'b0}}, va};
            end
        end
    end

    // Product register stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_valid <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                p_prod[i] <= '0;
            end
        end else if (adv) begin
            p_valid <= s_valid;
            if (s_valid) begin
                p_first <= s_first;
                p_last  <= s_last;
                for (int i = 0; i < LANES; i++) begin
                    p_prod[i] <= prod_c[i];
                end
            end
        end
    end

    // Next accumulator values: restart on first, otherwise add with optional clamping.
    always_comb begin
        logic [ACC_W-1:0] ext;
        logic [ACC_W:0]   sum;
        for (int i = 0; i < LANES; i++) begin
            if (SIGNED != 0) begin
                ext = ACC_W'($signed(p_prod[i]));
                sum = {acc[i][ACC_W-1], acc[i]} + {ext[ACC_W-1], ext};
            end else begin
                ext = ACC_W'(p_prod[i]);
                sum = {1'b0, acc[i]} + {1'b0, ext};
            end
            if (p_first) begin
                acc_nxt[i] = ext;
            end else if (SAT == 0) begin
                acc_nxt[i] = sum[ACC_W-1:0];
            end else if (SIGNED != 0) begin
                if (sum[ACC_W] != sum[ACC_W-1]) begin
                    acc_nxt[i] = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
                end else begin
                    acc_nxt[i] = sum[ACC_W-1:0];
                end
            end else begin
                acc_nxt[i] = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
            end
        end
        if (p_first) begin
            cnt_nxt = CNT_W'(1);
        end else if (&cnt) begin
            cnt_nxt = cnt;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    // Accumulate, track group state and sequencing errors, and publish the result on last.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LANES; i++) begin
                acc[i] <= '0;
            end
            cnt       <= '0;
            grp_open  <= 1'b0;
            err_seq   <= 1'b0;
            out_valid <= 1'b0;
            out_m     <= '0;
            out_beats <= '0;
        end else if (adv) begin
            out_valid <= p_valid && p_last;
            if (p_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    acc[i] <= acc_nxt[i];
                end
                cnt      <= cnt_nxt;
                grp_open <= !p_last;
                // first without an open group is fine; a mismatch either way is an error
                if (p_first == grp_open) begin
                    err_seq <= 1'b1;
                end
                if (p_last) begin
                    for (int i = 0; i < LANES; i++) begin
                        out_m[i*ACC_W +: ACC_W] <= acc_nxt[i];
                    end
                    out_beats <= cnt_nxt;
                end
            end
        end
    end

endmodule
